cla_seg_adder_seq: RTL

Multi-cycle wide two's-complement adder for the MAC512 datapath. It adds two WIDTH-bit operands SEG bits per clock. Each segment's sum comes from per-bit P/G generation feeding 4-bit lookahead groups, and the group Pout/Gout signals are chained across the segment. The carry between segments is held in a register. The block sits directly upstream of the accumulator register and trades latency for a short critical path.

---
 rtl/cla_seg_adder_seq.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/cla_seg_adder_seq.sv
// -----------------------------------------------------------------------------
// cla_seg_adder_seq
//
// Multi-cycle wide two's-complement adder for the MAC512 datapath. Operands
// are latched on the accepting edge and added SEG bits per clock. Each segment
// is built from per-bit propagate/generate terms feeding 4-bit carry-lookahead
// groups. The group Pout/Gout terms are chained across the segment. The carry
// between segments lives in a register, which keeps the critical path to one
// segment at the cost of NSEG cycles of latency.
//
// Parameters
//   WIDTH  operand/result width, a multiple of SEG
//   SEG    bits added per cycle, a multiple of 4
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   request, only looked at in IDLE
//   a, b   in   WIDTH-bit operands, captured on the accepting edge
//   cin    in   carry-in, captured on the accepting edge
//   busy   out  high while an operation is in RUN or DONE
//   done   out  one-cycle pulse, result valid
//   sum    out  registered WIDTH-bit result
//   cout   out  carry out of bit WIDTH-1
//   ovf    out  signed overflow
// -----------------------------------------------------------------------------
module cla_seg_adder_seq #(
    parameter int WIDTH = 64,
    parameter int SEG   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NSEG  = WIDTH / SEG;
    localparam int NGRP  = SEG / 4;
    localparam int IDX_W = (NSEG > 1) ? $clog2(NSEG) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSEG - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q,   idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q,     a_d;
    logic [WIDTH-1:0] b_q,     b_d;
    logic [WIDTH-1:0] sum_q,   sum_d;
    logic             cout_q,  cout_d;
    logic             ovf_q,   ovf_d;

    // -------------------------------------------------------------------------
    // Segment arithmetic signals
    // -------------------------------------------------------------------------
    logic [SEG-1:0]   seg_a;
    logic [SEG-1:0]   seg_b;
    logic [SEG-1:0]   seg_p;
    logic [SEG-1:0]   seg_g;
    logic [SEG-1:0]   seg_c;     // carry into each bit of the segment
    logic [SEG-1:0]   seg_sum;
    logic             seg_cout;
    logic             seg_ovf;
    logic             grp_carry; // running carry between lookahead groups
    logic [5:0]       grp_res;

    // -------------------------------------------------------------------------
    // 4-bit lookahead group.
    // Returns {gout, pout, c3, c2, c1, c0}, where c0..c3 are the carries into
    // the four bits of the group. c0 is simply the group carry-in.
    // -------------------------------------------------------------------------
    function automatic logic [5:0] cla4(
        input logic [3:0] p,
        input logic [3:0] g,
        input logic       c0
    );
        logic c1;
        logic c2;
        logic c3;
        logic pout;
        logic gout;
        c1   = g[0] | (p[0] & c0);
        c2   = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c3   = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                    | (p[2] & p[1] & p[0] & c0);
        pout = &p;
        gout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                    | (p[3] & p[2] & p[1] & g[0]);
        return {gout, pout, c3, c2, c1, c0};
    endfunction

    // -------------------------------------------------------------------------
    // Segment adder: selects the active segment of the latched operands and
    // adds it with the registered inter-segment carry.
    // -------------------------------------------------------------------------
    always_comb begin
        seg_a = '0;
        seg_b = '0;
        // Constant-select mux over segments keeps every part-select static.
        for (int s = 0; s < NSEG; s++) begin
            if (idx_q == IDX_W'(s)) begin
                seg_a = a_q[s*SEG +: SEG];
                seg_b = b_q[s*SEG +: SEG];
            end
        end

        seg_p = seg_a ^ seg_b;
        seg_g = seg_a & seg_b;

        seg_c     = '0;
        grp_res   = '0;
        grp_carry = carry_q;
        for (int g = 0; g < NGRP; g++) begin
            grp_res          = cla4(seg_p[4*g +: 4], seg_g[4*g +: 4], grp_carry);
            seg_c[4*g +: 4]  = grp_res[3:0];
            // c(j+1) = Gout(j) | Pout(j) & c(j)
            grp_carry        = grp_res[5] | (grp_res[4] & grp_carry);
        end

        seg_cout = grp_carry;
        seg_sum  = seg_p ^ seg_c;
        // Only meaningful on the top segment, where seg_c[SEG-1] is the carry
        // into bit WIDTH-1.
        seg_ovf  = seg_c[SEG-1] ^ grp_carry;
    end

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        busy = (state_q == ST_RUN) || (state_q == ST_DONE);
        done = (state_q == ST_DONE);
    end

    // -------------------------------------------------------------------------
    // Datapath next-value logic
    // -------------------------------------------------------------------------
    always_comb begin
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                end
            end
            ST_RUN: begin
                for (int s = 0; s < NSEG; s++) begin
                    if (idx_q == IDX_W'(s)) begin
                        sum_d[s*SEG +: SEG] = seg_sum;
                    end
                end
                carry_d = seg_cout;
                if (idx_q == LAST_IDX) begin
                    idx_d  = '0;
                    cout_d = seg_cout;
                    ovf_d  = seg_ovf;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: begin
                // DONE holds everything; the result stays visible.
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule
